mavg3_channel_scheduler: RTL and testbench
==========================================

MAVG3_CHANNEL_SCHEDULER -- requirements
Module: mavg3_channel_scheduler

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the signed sample width; the output sum width SHALL be DATA_W+2.
REQ-002 Parameter NCH SHALL be fixed at 4 (number of requesting channels); other values are unsupported.
REQ-003 Port system1000, in, 1: single clock; all state SHALL update on its rising edge only.
REQ-004 Port system1000_rst, in, 1: synchronous, active-high reset.
REQ-005 Port req_valid, in, 4: per-channel sample-valid flags.
REQ-006 Port req_data, in, 4*DATA_W: channel k sample, signed, at bits [k*DATA_W +: DATA_W].
REQ-007 Port req_ready, out, 4: per-channel grant; at most one bit high.
REQ-008 Port flush, in, 4: per-channel command to clear that channel's history.
REQ-009 Port out_valid, out, 1: result-valid flag.
REQ-010 Port out_chan, out, 2: channel index of the result.
REQ-011 Port out_sum, out, DATA_W+2: signed 3-tap window sum.
REQ-012 Port out_ready, in, 1: downstream backpressure.

Function
REQ-013 Channel k context SHALL consist of hist1 and hist2 (previous two accepted samples, signed) and a fill count saturating at 2.
REQ-014 can_accept SHALL be (!out_valid || out_ready).
REQ-015 The arbiter SHALL be round-robin: search starts at (last_grant+1) mod 4 and wraps; the first channel with req_valid high wins.
REQ-016 req_ready SHALL be combinational: one-hot winner when can_accept, all-zero otherwise.
REQ-017 A transfer occurs on channel k when req_valid[k] && req_ready[k]; last_grant SHALL update only on a transfer.
REQ-018 On a transfer, out_sum SHALL be registered as sext(x0)+sext(hist1)+sext(hist2) with x0 = new sample; out_chan = k; out_valid = 1; latency exactly 1 cycle.
REQ-019 Arithmetic SHALL be full-precision signed DATA_W+2 with no overflow (DATA_W=8: -384..381).
REQ-020 On a transfer, channel k SHALL shift: hist2<=hist1, hist1<=x0, fill<=min(fill+1,2).
REQ-021 Missing history entries (fill<2) SHALL contribute 0 to the sum.
REQ-022 With out_valid high and out_ready low, out_valid, out_chan and out_sum SHALL hold stable and no transfer SHALL occur.
REQ-023 out_valid SHALL clear after a cycle with out_ready high and no transfer.
REQ-024 flush[k] SHALL clear hist1, hist2 and fill of channel k at the clock edge.
REQ-025 When flush[k] and a transfer on k coincide, the result SHALL use the pre-flush context and the flush SHALL win (context cleared, sample not stored).
REQ-026 A channel whose req_valid drops before grant SHALL lose no state; requests SHALL NOT be queued.

Reset
REQ-027 While system1000_rst is high: out_valid=0, out_chan=0, out_sum=0, last_grant=3 (channel 0 has first priority), all hist and fill = 0.
REQ-028 req_ready SHALL be all-zero during any reset cycle.
REQ-029 Reset asserted mid-stream SHALL discard any pending result and all channel history in the same edge.

Configuration
REQ-030 Macro MAVG3_SCHED_WARMUP_EN, when defined: a transfer with fill<2 SHALL update the context but leave out_valid low (no result produced); only full windows are emitted.
REQ-031 Without MAVG3_SCHED_WARMUP_EN: every transfer SHALL produce a result, zero-padded per REQ-021.

Verification
REQ-032 Ch0 only, samples 10,20,30,-5, out_ready=1 -> out_sum 10,30,60,45 (macro off); 60,45 only (macro on); each 1 cycle after acceptance.
REQ-033 All four req_valid high for 8 cycles, out_ready=1 -> grant order 0,1,2,3,0,1,2,3; one result per cycle.
REQ-034 Ch2 samples 127,127,127 -> out_sum 381; samples -128,-128,-128 -> out_sum -384.
REQ-035 out_ready low 3 cycles with result pending -> req_ready=0, outputs frozen; on release exactly one result consumed, next transfer next cycle.
REQ-036 Ch1 history 5,6, then flush[1] with sample 7 -> out_sum 18; next sample 4 -> out_sum 4 (macro off) or none (macro on).
REQ-037 Reset asserted between two ch3 transfers -> out_valid 0 next cycle; the following ch3 sample 9 yields out_sum 9 (macro off).

Source files
------------

// File: rtl/mavg3_channel_scheduler_if.sv
// Request/result bundle for the 4-channel 3-tap moving-average scheduler.
// slave = scheduler side, master = traffic source/sink side.
interface mavg3_channel_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic [3:0]          flush;
  logic                out_valid;
  logic [1:0]          out_chan;
  logic [DATA_W+1:0]   out_sum;
  logic                out_ready;

  modport slave (
    input  req_valid, req_data, flush, out_ready,
    output req_ready, out_valid, out_chan, out_sum
  );

  modport master (
    output req_valid, req_data, flush, out_ready,
    input  req_ready, out_valid, out_chan, out_sum
  );
endinterface

// File: rtl/mavg3_channel_scheduler.sv
// Round-robin 4-channel scheduler with per-channel 3-tap window sum.
// MAVG3_SCHED_WARMUP_EN: suppress results until a channel's window is full.
module mavg3_channel_scheduler #(
  parameter int DATA_W = 8,
  parameter int NCH    = 4
) (
  input logic                           system1000,
  input logic                           system1000_rst,
  mavg3_channel_scheduler_if.slave      bus
);
  localparam int SW = DATA_W + 2;

  logic signed [DATA_W-1:0] hist1_q [NCH];
  logic signed [DATA_W-1:0] hist1_d [NCH];
  logic signed [DATA_W-1:0] hist2_q [NCH];
  logic signed [DATA_W-1:0] hist2_d [NCH];
  logic [1:0]               fill_q  [NCH];
  logic [1:0]               fill_d  [NCH];

  logic [1:0]           last_q, last_d;
  logic                 out_valid_q, out_valid_d;
  logic [1:0]           out_chan_q, out_chan_d;
  logic signed [SW-1:0] out_sum_q, out_sum_d;

  logic                     can_accept;
  logic [1:0]               idx;
  logic [1:0]               win;
  logic                     win_ok;
  logic [NCH-1:0]           grant;
  logic                     xfer;
  logic                     emit;
  logic signed [DATA_W-1:0] x0;
  logic signed [SW-1:0]     sum;

  function automatic logic signed [SW-1:0] sext(
    input logic signed [DATA_W-1:0] v
  );
    return {{2{v[DATA_W-1]}}, v};
  endfunction

  // search begins one past the last granted channel and wraps
  always_comb begin
    idx    = '0;
    win    = '0;
    win_ok = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = last_q + 2'(i);
      if (!win_ok && bus.req_valid[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  assign can_accept = !out_valid_q || bus.out_ready;

  always_comb begin
    grant = '0;
    if (win_ok && can_accept && !system1000_rst)
      grant = NCH'(1) << win;
  end

  assign xfer = |grant;
  assign x0   = bus.req_data[win*DATA_W +: DATA_W];

  always_comb begin
    sum = sext(x0);
    if (fill_q[win] != 2'd0)
      sum = sum + sext(hist1_q[win]);
    if (fill_q[win] == 2'd2)
      sum = sum + sext(hist2_q[win]);
  end

`ifdef MAVG3_SCHED_WARMUP_EN
  assign emit = xfer && (fill_q[win] == 2'd2);
`else
  assign emit = xfer;
`endif

  always_comb begin
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_sum_d   = out_sum_q;
    if (xfer)
      last_d = win;
    if (emit) begin
      out_valid_d = 1'b1;
      out_chan_d  = win;
      out_sum_d   = sum;
    end else if (xfer || bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // flush overrides a coincident shift: the sample is not kept
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      hist1_d[k] = hist1_q[k];
      hist2_d[k] = hist2_q[k];
      fill_d[k]  = fill_q[k];
      if (xfer && win == 2'(k)) begin
        hist2_d[k] = hist1_q[k];
        hist1_d[k] = x0;
        fill_d[k]  = (fill_q[k] == 2'd2) ? 2'd2 : fill_q[k] + 2'd1;
      end
      if (bus.flush[k]) begin
        hist1_d[k] = '0;
        hist2_d[k] = '0;
        fill_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      last_q      <= 2'd3;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_sum_q   <= '0;
      for (int k = 0; k < NCH; k++) begin
        hist1_q[k] <= '0;
        hist2_q[k] <= '0;
        fill_q[k]  <= '0;
      end
    end else begin
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_sum_q   <= out_sum_d;
      for (int k = 0; k < NCH; k++) begin
        hist1_q[k] <= hist1_d[k];
        hist2_q[k] <= hist2_d[k];
        fill_q[k]  <= fill_d[k];
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_sum   = out_sum_q;
endmodule

// File: tb/tb_mavg3_channel_scheduler.sv
// Bench for mavg3_channel_scheduler: directed cases then random traffic
// against a queue-based reference model.
module tb_mavg3_channel_scheduler;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mavg3_channel_scheduler_if #(.DATA_W(DW)) bus ();

  mavg3_channel_scheduler #(
    .DATA_W(DW),
    .NCH(4)
  ) dut (
    .system1000(clk),
    .system1000_rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int hist [4][$];
  int m_last;
  bit m_ov;
  int m_chan;
  int m_sum;

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(bit r, logic [3:0] v, logic [3:0] fl, bit ordy);
    rst           = r;
    bus.req_valid = v;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  task automatic sd(int ch, int val);
    bus.req_data[ch*DW +: DW] = DW'(val);
  endtask

  task automatic tick();
    logic [3:0]          g;
    int                  k;
    int                  c;
    int                  s;
    bit                  emit;
    logic signed [DW-1:0] xs;
    logic signed [31:0]  os;
    #1;
    g = '0;
    k = 0;
    if (!rst && (!m_ov || bus.out_ready)) begin
      for (int o = 1; o <= 4; o++) begin
        c = (m_last + o) % 4;
        if (g == 0 && bus.req_valid[c]) begin
          g = 4'(1 << c);
          k = c;
        end
      end
    end
    chk("req_ready", {28'b0, bus.req_ready}, {28'b0, g});
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i].delete();
      m_last = 3;
      m_ov   = 0;
      m_chan = 0;
      m_sum  = 0;
    end else begin
      if (g != 0) begin
        xs = bus.req_data[k*DW +: DW];
        s  = xs;
        for (int j = 0; j < hist[k].size(); j++) s += hist[k][j];
`ifdef MAVG3_SCHED_WARMUP_EN
        emit = (hist[k].size() == 2);
`else
        emit = 1'b1;
`endif
        if (emit) begin
          m_ov   = 1;
          m_chan = k;
          m_sum  = s;
        end else begin
          m_ov = 0;
        end
        m_last = k;
        hist[k].push_front(int'(xs));
        if (hist[k].size() > 2) void'(hist[k].pop_back());
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
      for (int i = 0; i < 4; i++)
        if (bus.flush[i]) hist[i].delete();
    end
    @(posedge clk);
    #1;
    os = $signed(bus.out_sum);
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
    chk("out_chan", {30'b0, bus.out_chan}, m_chan);
    chk("out_sum", os, m_sum);
  endtask

  function automatic logic signed [31:0] osum();
    logic signed [31:0] v;
    v = $signed(bus.out_sum);
    return v;
  endfunction

  initial begin
    int s32 [4];
    s32 = '{10, 20, 30, -5};
    bus.req_data = '0;
    m_last = 3;
    m_ov   = 0;
    m_chan = 0;
    m_sum  = 0;

    drive(1, 4'h0, 4'h0, 1);
    tick();
    drive(1, 4'hF, 4'h0, 1);
    tick();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_out_sum", osum(), 0);

    for (int i = 0; i < 4; i++) begin
      drive(0, 4'b0001, 4'h0, 1);
      sd(0, s32[i]);
      tick();
    end
`ifndef MAVG3_SCHED_WARMUP_EN
    chk("r032_last", osum(), 45);
`else
    chk("r032_last", osum(), 45);
`endif
    drive(0, 4'h0, 4'h0, 1);
    tick();

    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b0100, 4'h0, 1);
      sd(2, 127);
      tick();
    end
    chk("r034_max", osum(), 381);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b0100, 4'h0, 1);
      sd(2, -128);
      tick();
    end
    chk("r034_min", osum(), -384);

    for (int i = 0; i < 3; i++) begin
      drive(0, 4'hF, 4'h0, 0);
      tick();
      chk("r035_frozen", osum(), -384);
    end
    drive(0, 4'hF, 4'h0, 1);
    tick();

    drive(0, 4'h0, 4'b0010, 1);
    tick();
    drive(0, 4'b0010, 4'h0, 1);
    sd(1, 5);
    tick();
    sd(1, 6);
    tick();
    drive(0, 4'b0010, 4'b0010, 1);
    sd(1, 7);
    tick();
    chk("r036_flush", osum(), 18);
    drive(0, 4'b0010, 4'h0, 1);
    sd(1, 4);
    tick();
`ifndef MAVG3_SCHED_WARMUP_EN
    chk("r036_after", osum(), 4);
`else
    chk("r036_after", {31'b0, bus.out_valid}, 0);
`endif

    drive(1, 4'h0, 4'h0, 1);
    tick();
    drive(0, 4'hF, 4'h0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r033_chan", {30'b0, bus.out_chan}, i % 4);
    end

    drive(0, 4'b1000, 4'h0, 1);
    sd(3, 3);
    tick();
    drive(1, 4'b1000, 4'h0, 1);
    tick();
    chk("r037_rst", {31'b0, bus.out_valid}, 0);
    drive(0, 4'b1000, 4'h0, 1);
    sd(3, 9);
    tick();
`ifndef MAVG3_SCHED_WARMUP_EN
    chk("r037_sum", osum(), 9);
`endif

    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 63) == 0),
            4'($urandom),
            4'($urandom & $urandom & $urandom),
            ($urandom_range(0, 3) != 0));
      for (int c = 0; c < 4; c++) sd(c, int'($urandom_range(0, 255)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
